// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz Wishbone sweep master: FSM states,
// slave register map and the CTRL word encoding.
package collatz_pkg;

    localparam int SEED_W = 16;

    localparam logic [31:0] CTRL_OFS = 32'h0000_0000;
    localparam logic [31:0] STAT_OFS = 32'h0000_0004;
    localparam int          ST_BIT   = 16;
    localparam int          BS_BIT   = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_CTRL = 3'd1,
        S_POLL    = 3'd2,
        S_NEXT    = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    function automatic logic [31:0] ctrl_word(input logic [SEED_W-1:0] seed);
        logic [31:0] w;
        w                = '0;
        w[ST_BIT]        = 1'b1;
        w[SEED_W-1:0]    = seed;
        return w;
    endfunction

endpackage

// File: rtl/collatz_wbm_xfer.sv
// Single-transfer Wishbone classic engine. Optional ack timeout is enabled
// by defining COLLATZ_WBM_TIMEOUT_EN.
module collatz_wbm_xfer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    output logic        rsp_valid,
    output logic        rsp_timeout,
    input  logic        wbm_ack_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o
);

    // Handshake: a transfer launches on a cycle with req_valid && req_ready,
    // capturing req_we/adr/dat, which then stay frozen on the bus while stb
    // is high. rsp_valid (ack) or rsp_timeout is a single-cycle pulse ending
    // the transfer; req_ready returns the next cycle, giving a one-cycle gap.
    logic        active;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            dat_q  <= '0;
        end else if (!active) begin
            if (req_valid) begin
                active <= 1'b1;
                we_q   <= req_we;
                adr_q  <= req_adr;
                dat_q  <= req_dat;
            end
        end else if (rsp_valid || rsp_timeout) begin
            active <= 1'b0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            dat_q  <= '0;
        end
    end

    assign req_ready = !active;
    assign rsp_valid = active && wbm_ack_i;

`ifdef COLLATZ_WBM_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            wait_cnt <= '0;
        end else if (!wbm_ack_i) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Fires on the last permitted cycle so stb is high for exactly ACK_TIMEOUT cycles.
    assign rsp_timeout = active && !wbm_ack_i && (wait_cnt == CNT_W'(ACK_TIMEOUT - 1));
`else
    localparam int unused_ack_timeout = ACK_TIMEOUT;
    assign rsp_timeout = 1'b0;
`endif

    assign wbm_cyc_o = active;
    assign wbm_stb_o = active;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = active ? 4'hF : 4'h0;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: rtl/collatz_wb_master.sv
// Sweeps a seed range through a Wishbone Collatz slave and tracks the seed
// with the most steps. COLLATZ_WBM_TIMEOUT_EN enables the ack timeout / err_o.
module collatz_wb_master
    import collatz_pkg::*;
#(
    parameter logic [31:0] SLAVE_BASE  = 32'h3000_0000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [15:0] seed_first_i,
    input  logic [15:0] seed_last_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] max_steps_o,
    output logic [15:0] max_seed_o,
    output logic        err_o,
    output logic [3:0]  dbg_state_o
);

    state_t              state, state_nxt;
    logic [SEED_W-1:0]   seed, seed_last, result, max_steps, max_seed;
    logic                req_valid, req_ready, req_we, rsp_valid, rsp_timeout;
    logic [31:0]         req_adr, req_dat;
    logic                range_ok, stat_done, unused_dat;

    assign range_ok   = seed_first_i <= seed_last_i;
    assign stat_done  = wbm_dat_i[BS_BIT];
    assign unused_dat = &{1'b0, wbm_dat_i[31:BS_BIT+1]};

    // NEXT already presents the following CTRL write so the bus gap after the
    // final poll ack stays one cycle; WR_CTRL then just waits for its ack.
    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        req_we    = 1'b1;
        req_adr   = SLAVE_BASE + CTRL_OFS;
        req_dat   = ctrl_word(seed);
        case (state)
            S_IDLE: begin
                if (start_i) state_nxt = range_ok ? S_WR_CTRL : S_FIN;
            end
            S_WR_CTRL: begin
                req_valid = 1'b1;
                if (rsp_timeout)    state_nxt = S_FIN;
                else if (rsp_valid) state_nxt = S_POLL;
            end
            S_POLL: begin
                req_valid = 1'b1;
                req_we    = 1'b0;
                req_adr   = SLAVE_BASE + STAT_OFS;
                req_dat   = '0;
                if (rsp_timeout)                 state_nxt = S_FIN;
                else if (rsp_valid && stat_done) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (seed == seed_last) begin
                    state_nxt = S_FIN;
                end else begin
                    req_valid = 1'b1;
                    req_dat   = ctrl_word(seed + 16'd1);
                    state_nxt = S_WR_CTRL;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            seed      <= '0;
            seed_last <= '0;
            result    <= '0;
            max_steps <= '0;
            max_seed  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start_i && range_ok) begin
                        seed      <= seed_first_i;
                        seed_last <= seed_last_i;
                        max_steps <= '0;
                        max_seed  <= '0;
                    end
                end
                S_POLL: begin
                    if (rsp_valid && stat_done) result <= wbm_dat_i[SEED_W-1:0];
                end
                S_NEXT: begin
                    // Strict compare: a tie keeps the earlier seed.
                    if (result > max_steps) begin
                        max_steps <= result;
                        max_seed  <= seed;
                    end
                    if (seed != seed_last) seed <= seed + 16'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef COLLATZ_WBM_TIMEOUT_EN
    logic err;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            err <= 1'b0;
        end else if (state == S_IDLE && start_i) begin
            err <= 1'b0;
        end else if (rsp_timeout) begin
            err <= 1'b1;
        end
    end
    assign err_o = err;
`else
    assign err_o = 1'b0;
`endif

    collatz_wbm_xfer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_xfer (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_adr     (req_adr),
        .req_dat     (req_dat),
        .rsp_valid   (rsp_valid),
        .rsp_timeout (rsp_timeout),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o)
    );

    assign busy_o      = (state == S_WR_CTRL) || (state == S_POLL) || (state == S_NEXT);
    assign done_o      = (state == S_FIN);
    assign max_steps_o = max_steps;
    assign max_seed_o  = max_seed;
    assign dbg_state_o = {!req_ready, state};

endmodule

// File: tb/tb_collatz_wb_master.sv
// Directed bench for collatz_wb_master with a behavioural Wishbone Collatz slave.
module tb_collatz_wb_master;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seed_first, seed_last;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o, dbg_state_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        busy_o, done_o, err_o;
    logic [15:0] max_steps_o, max_seed_o;

    always #5 clk = ~clk;

    collatz_wb_master #(
        .SLAVE_BASE  (BASE),
        .ACK_TIMEOUT (8)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .start_i      (start),
        .seed_first_i (seed_first),
        .seed_last_i  (seed_last),
        .wbm_cyc_o    (wbm_cyc_o),
        .wbm_stb_o    (wbm_stb_o),
        .wbm_we_o     (wbm_we_o),
        .wbm_sel_o    (wbm_sel_o),
        .wbm_adr_o    (wbm_adr_o),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_ack_i    (wbm_ack_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .max_steps_o  (max_steps_o),
        .max_seed_o   (max_seed_o),
        .err_o        (err_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- slave model ----------------
    logic        ack_en = 1'b1;
    logic        use_tab = 1'b0;
    int          polls_needed = 0;
    logic [15:0] res_tab [16];
    logic        ack_r = 1'b0;
    logic [31:0] rd_r = 32'h0;
    logic        force_ack = 1'b0;
    logic [31:0] force_dat = 32'h0;
    logic [15:0] cur_seed = 16'h0;
    int          poll_cnt = 0;
    int          n_wr = 0, n_rd = 0, addr_bad = 0;
    logic [31:0] wr_log [$];

    assign wbm_ack_i = ack_r | force_ack;
    assign wbm_dat_i = force_ack ? force_dat : rd_r;

    function automatic logic [15:0] collatz_steps(input logic [15:0] s);
        longint unsigned v;
        int n;
        v = 64'(s);
        n = 0;
        while (v > 1) begin
            if (v[0]) v = 3 * v + 1;
            else      v = v >> 1;
            n++;
        end
        return 16'(n);
    endfunction

    function automatic logic [15:0] slave_result(input logic [15:0] s);
        return use_tab ? res_tab[s[3:0]] : collatz_steps(s);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ack_r <= 1'b0;
        end else if (wbm_cyc_o && wbm_stb_o && !ack_r && ack_en) begin
            ack_r <= 1'b1;
            if (wbm_we_o) begin
                if (wbm_adr_o != BASE) addr_bad <= addr_bad + 1;
                wr_log.push_back(wbm_dat_o);
                n_wr     <= n_wr + 1;
                cur_seed <= wbm_dat_o[15:0];
                poll_cnt <= 0;
                rd_r     <= 32'h0;
            end else begin
                if (wbm_adr_o != BASE + 32'h4) addr_bad <= addr_bad + 1;
                n_rd <= n_rd + 1;
                if (poll_cnt < polls_needed) begin
                    poll_cnt <= poll_cnt + 1;
                    rd_r     <= 32'h0;
                end else begin
                    rd_r <= {15'h0, 1'b1, slave_result(cur_seed)};
                end
            end
        end else begin
            ack_r <= 1'b0;
        end
    end

    // ---------------- bus protocol monitor ----------------
    int          done_cnt = 0, done_long = 0, cyc_cnt = 0, stb_chg = 0, sel_bad = 0;
    int          gap_seen = 0, gap_bad = 0, gap_run = 0;
    logic        in_gap = 1'b0, prev_stb = 1'b0, prev_done = 1'b0;
    logic [31:0] hold_adr = 32'h0, hold_dat = 32'h0;

    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (done_o && prev_done) done_long++;
        if (wbm_cyc_o) cyc_cnt++;
        if (!wbm_stb_o && wbm_sel_o != 4'h0) sel_bad++;
        if (wbm_stb_o && prev_stb &&
            (wbm_adr_o != hold_adr || wbm_dat_o != hold_dat || wbm_sel_o != 4'hF)) stb_chg++;
        if (wbm_stb_o && !prev_stb) begin
            if (in_gap && busy_o) begin
                gap_seen++;
                if (gap_run != 1) gap_bad++;
            end
            in_gap   = 1'b0;
            hold_adr = wbm_adr_o;
            hold_dat = wbm_dat_o;
        end
        if (!wbm_stb_o && prev_stb) begin
            in_gap  = 1'b1;
            gap_run = 0;
        end
        if (!wbm_stb_o && in_gap) gap_run++;
        if (!busy_o) in_gap = 1'b0;
        prev_stb  = wbm_stb_o;
        prev_done = done_o;
    end

    // ---------------- checking helpers ----------------
    int          n_tests = 0, n_fail = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_sweep(input logic [15:0] f, input logic [15:0] l);
        seed_first = f;
        seed_last  = l;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, done_o}, 32'd1);
    endtask

    task automatic check_log(input string tag, input int base);
        int idx;
        idx = base;
        while (exp_q.size() > 0) begin
            check(tag, (idx < wr_log.size()) ? wr_log[idx] : 32'hDEAD_BEEF, exp_q.pop_front());
            idx++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w0, r0, d0, c0, n;
        rst        = 1'b1;
        start      = 1'b0;
        seed_first = 16'h0;
        seed_last  = 16'h0;
        for (int i = 0; i < 16; i++) res_tab[i] = 16'h0;
        tick(3);
        check("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        check("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
        check("rst_sel", {28'b0, wbm_sel_o}, 32'd0);
        check("rst_adr", wbm_adr_o, 32'd0);
        check("rst_busy_done", {30'b0, busy_o, done_o}, 32'd0);
        check("rst_max", {max_steps_o, max_seed_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Seed 27, slave reports done on the 4th poll with 111 steps.
        use_tab = 1'b1; res_tab[11] = 16'd111; polls_needed = 3;
        w0 = n_wr; r0 = n_rd; d0 = done_cnt;
        start_sweep(16'd27, 16'd27);
        check("lat_stb_c1", {31'b0, wbm_stb_o}, 32'd0);
        check("lat_busy_c1", {31'b0, busy_o}, 32'd1);
        tick(1);
        check("lat_stb_c2", {30'b0, wbm_cyc_o, wbm_stb_o}, 32'd3);
        check("wr27_we_sel", {27'b0, wbm_we_o, wbm_sel_o}, 32'h1F);
        check("wr27_adr", wbm_adr_o, BASE);
        check("wr27_dat", wbm_dat_o, 32'h0001_001B);
        wait_done("s27_done", 300);
        tick(3);
        check("s27_writes", n_wr - w0, 32'd1);
        check("s27_reads", n_rd - r0, 32'd4);
        check("s27_done_pulses", done_cnt - d0, 32'd1);
        check("s27_max_steps", {16'b0, max_steps_o}, 32'd111);
        check("s27_max_seed", {16'b0, max_seed_o}, 32'd27);
        check("s27_busy", {31'b0, busy_o}, 32'd0);
        check("s27_err", {31'b0, err_o}, 32'd0);

        // Range 1..10 with true step counts: seed 9 wins with 19 steps.
        use_tab = 1'b0; polls_needed = 1;
        w0 = n_wr;
        start_sweep(16'd1, 16'd10);
        wait_done("r10_done", 2000);
        tick(2);
        check("r10_writes", n_wr - w0, 32'd10);
        check("r10_max_steps", {16'b0, max_steps_o}, 32'd19);
        check("r10_max_seed", {16'b0, max_seed_o}, 32'd9);
        for (int i = 1; i <= 10; i++) exp_q.push_back(32'h0001_0000 | 32'(i));
        check_log("r10_ctrl", w0);

        // Tie: results 5,7,7 for seeds 3,4,5 keep seed 4.
        use_tab = 1'b1; polls_needed = 0;
        res_tab[3] = 16'd5; res_tab[4] = 16'd7; res_tab[5] = 16'd7;
        start_sweep(16'd3, 16'd5);
        wait_done("tie_done", 500);
        check("tie_max_steps", {16'b0, max_steps_o}, 32'd7);
        check("tie_max_seed", {16'b0, max_seed_o}, 32'd4);
        tick(2);

        // Empty range: done pulse next cycle, no bus activity.
        w0 = n_wr; c0 = cyc_cnt; d0 = done_cnt;
        start_sweep(16'd5, 16'd3);
        check("empty_done_next", {30'b0, done_o, busy_o}, 32'd2);
        tick(5);
        check("empty_done_pulses", done_cnt - d0, 32'd1);
        check("empty_no_cyc", cyc_cnt - c0, 32'd0);
        check("empty_no_write", n_wr - w0, 32'd0);

        // start_i during a sweep is ignored.
        use_tab = 1'b0; polls_needed = 2;
        w0 = n_wr;
        start_sweep(16'd1, 16'd3);
        tick(4);
        check("ign_busy", {31'b0, busy_o}, 32'd1);
        start_sweep(16'd100, 16'd200);
        wait_done("ign_done", 1000);
        tick(2);
        check("ign_writes", n_wr - w0, 32'd3);
        check("ign_max_steps", {16'b0, max_steps_o}, 32'd7);
        check("ign_max_seed", {16'b0, max_seed_o}, 32'd3);
        for (int i = 1; i <= 3; i++) exp_q.push_back(32'h0001_0000 | 32'(i));
        check_log("ign_ctrl", w0);

        // Top of the seed space terminates without wrapping.
        use_tab = 1'b1; polls_needed = 0;
        res_tab[14] = 16'd3; res_tab[15] = 16'd9;
        w0 = n_wr;
        start_sweep(16'hFFFE, 16'hFFFF);
        wait_done("wrap_done", 500);
        tick(20);
        check("wrap_writes", n_wr - w0, 32'd2);
        check("wrap_idle", {31'b0, busy_o}, 32'd0);
        check("wrap_max", {max_steps_o, max_seed_o}, 32'h0009_FFFF);
        exp_q.push_back(32'h0001_FFFE);
        exp_q.push_back(32'h0001_FFFF);
        check_log("wrap_ctrl", w0);

        // Reset while stb waits for ack; a late ack must be ignored.
        ack_en = 1'b0;
        d0 = done_cnt;
        start_sweep(16'd27, 16'd27);
        tick(3);
        check("rmid_stb_before", {31'b0, wbm_stb_o}, 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rmid_cyc_stb_busy", {29'b0, wbm_cyc_o, wbm_stb_o, busy_o}, 32'd0);
        check("rmid_max", {max_steps_o, max_seed_o}, 32'd0);
        force_dat = 32'h0001_0005;
        force_ack = 1'b1;
        tick(1);
        force_ack = 1'b0;
        tick(3);
        check("rmid_late_ack_state", {28'b0, dbg_state_o}, 32'd0);
        check("rmid_late_ack_outs", {29'b0, wbm_cyc_o, busy_o, done_o}, 32'd0);
        check("rmid_no_done", done_cnt - d0, 32'd0);
        check("rmid_max_after", {max_steps_o, max_seed_o}, 32'd0);

`ifdef COLLATZ_WBM_TIMEOUT_EN
        // Slave never acks: stb held exactly ACK_TIMEOUT cycles, then err and done.
        start_sweep(16'd27, 16'd27);
        tick(1);
        n = 0;
        while (wbm_stb_o && n < 100) begin
            n++;
            tick(1);
        end
        check("to_stb_cycles", n, 32'd8);
        check("to_err", {31'b0, err_o}, 32'd1);
        wait_done("to_done", 4);
        tick(1);
        check("to_idle", {30'b0, busy_o, wbm_cyc_o}, 32'd0);
        check("to_err_sticky", {31'b0, err_o}, 32'd1);
        ack_en = 1'b1; use_tab = 1'b1; polls_needed = 0; res_tab[11] = 16'd4;
        start_sweep(16'd27, 16'd27);
        check("to_err_cleared", {31'b0, err_o}, 32'd0);
        wait_done("to_recover_done", 200);
        check("to_recover_max", {max_steps_o, max_seed_o}, 32'h0004_001B);
`else
        // Without the timeout the master waits on the bus indefinitely.
        start_sweep(16'd27, 16'd27);
        tick(1);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!wbm_stb_o || err_o) n++;
            tick(1);
        end
        check("noto_stb_held", n, 32'd0);
        check("noto_busy", {31'b0, busy_o}, 32'd1);
        check("noto_err", {31'b0, err_o}, 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        ack_en = 1'b1;
        tick(2);
`endif

        check("mon_gap_seen", {31'b0, (gap_seen > 0)}, 32'd1);
        check("mon_gap_one_cycle", gap_bad, 32'd0);
        check("mon_stable_while_stb", stb_chg, 32'd0);
        check("mon_sel_idle", sel_bad, 32'd0);
        check("mon_done_width", done_long, 32'd0);
        check("mon_addr_map", addr_bad, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
